// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined block-CLA adder/subtractor with optional signed saturation
// Each stage adds one slice; carry and unconsumed operand slices are skewed into the next stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SLICE = WIDTH / STAGES;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Lookahead inside each BLOCK-bit group, group carries ripple to the next group.
    function automatic logic [SLICE:0] cla_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             c);
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] s;
        logic             cg;
        logic             cg_next;
        logic             gen;
        logic             prop;
        logic             cj;
        p       = x ^ y;
        g       = x & y;
        s       = '0;
        cg      = c;
        cg_next = 1'b0;
        for (int base = 0; base < SLICE; base += BLOCK) begin
            for (int i = 0; i <= BLOCK; i++) begin
                gen  = 1'b0;
                prop = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    gen  = gen | (g[base+j] & prop);
                    prop = prop & p[base+j];
                end
                cj = gen | (prop & cg);
                if (i < BLOCK) begin
                    s[base+i] = p[base+i] ^ cj;
                end else begin
                    cg_next = cj;
                end
            end
            cg = cg_next;
        end
        return {cg, s};
    endfunction

    logic [STAGES:0]   adv;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    assign b_eff       = op[0] ? ~b : b;
    assign c0          = (op == OP_ADD) ? cin : op[0];
    assign adv[STAGES] = out_ready;
    assign in_ready    = adv[0];

    genvar k;
    for (k = 0; k < STAGES; k++) begin : stg
        logic [SLICE-1:0]         xa;
        logic [SLICE-1:0]         xb;
        logic                     ci;
        logic                     vi;
        logic [1:0]               opi;
        logic                     ami;
        logic                     bmi;
        logic [SLICE:0]           res;
        logic                     v_q;
        logic [(k+1)*SLICE-1:0]   s_q;
        logic                     c_q;
        logic [1:0]               op_q;
        logic                     am_q;
        logic                     bm_q;

        // A stage moves when empty or when its successor moves, so bubbles collapse.
        assign adv[k] = !v_q || adv[k+1];
        assign vld[k] = v_q;
        assign res    = cla_add(xa, xb, ci);

        if (k == 0) begin : g_src
            assign xa  = a[SLICE-1:0];
            assign xb  = b_eff[SLICE-1:0];
            assign ci  = c0;
            assign vi  = in_valid;
            assign opi = op;
            assign ami = a[WIDTH-1];
            assign bmi = b_eff[WIDTH-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q <= '0;
                end else if (adv[k]) begin
                    s_q <= res[SLICE-1:0];
                end
            end
        end else begin : g_src
            assign xa  = stg[k-1].g_rest.ar_q[SLICE-1:0];
            assign xb  = stg[k-1].g_rest.br_q[SLICE-1:0];
            assign ci  = stg[k-1].c_q;
            assign vi  = stg[k-1].v_q;
            assign opi = stg[k-1].op_q;
            assign ami = stg[k-1].am_q;
            assign bmi = stg[k-1].bm_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q <= '0;
                end else if (adv[k]) begin
                    s_q <= {res[SLICE-1:0], stg[k-1].s_q};
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                op_q <= 2'b00;
                am_q <= 1'b0;
                bm_q <= 1'b0;
            end else if (adv[k]) begin
                v_q  <= vi;
                c_q  <= res[SLICE];
                op_q <= opi;
                am_q <= ami;
                bm_q <= bmi;
            end
        end

        if (k < STAGES - 1) begin : g_rest
            logic [(STAGES-1-k)*SLICE-1:0] ar_q;
            logic [(STAGES-1-k)*SLICE-1:0] br_q;

            if (k == 0) begin : g_ld
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ar_q <= '0;
                        br_q <= '0;
                    end else if (adv[k]) begin
                        ar_q <= a[WIDTH-1:SLICE];
                        br_q <= b_eff[WIDTH-1:SLICE];
                    end
                end
            end else begin : g_ld
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ar_q <= '0;
                        br_q <= '0;
                    end else if (adv[k]) begin
                        ar_q <= stg[k-1].g_rest.ar_q[(STAGES-k)*SLICE-1:SLICE];
                        br_q <= stg[k-1].g_rest.br_q[(STAGES-k)*SLICE-1:SLICE];
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] raw_sum;
    logic             last_am;
    logic             last_bm;
    logic             ovf;
    logic             sat;
    logic [WIDTH-1:0] res_sum;

    assign raw_sum = stg[STAGES-1].s_q;
    assign last_am = stg[STAGES-1].am_q;
    assign last_bm = stg[STAGES-1].bm_q;
    assign ovf     = (last_am == last_bm) && (raw_sum[WIDTH-1] != last_am);
    assign sat     = stg[STAGES-1].op_q[1] && ovf;
    assign res_sum = sat ? (last_am ? MINNEG : MAXPOS) : raw_sum;

    assign out_valid = vld[STAGES-1];
    assign sum       = res_sum;
    assign cout      = stg[STAGES-1].c_q;
    assign overflow  = ovf;
    assign zero      = out_valid && (res_sum == '0);
    assign negative  = res_sum[WIDTH-1];

endmodule
